// File: rtl/step_motor_ramp_if.sv
// Command/status bundle between the register file (master) and the step/dir
// pulse generator (slave), including the stepper driver pins.
interface step_motor_ramp_if #(
  parameter int C_STEP_NUMBER_WIDTH = 16,
  parameter int C_SPEED_DATA_WIDTH  = 16,
  parameter int C_POS_WIDTH         = 32
);
  logic                           i_clk_en;
  logic [C_SPEED_DATA_WIDTH-1:0]  i_period_min;
  logic [C_SPEED_DATA_WIDTH-1:0]  i_period_start;
  logic [C_SPEED_DATA_WIDTH-1:0]  i_accel;
  logic                           i_ramp_en;
  logic [C_STEP_NUMBER_WIDTH-1:0] i_step_nbr;
  logic                           i_start;
  logic                           i_stop;
  logic                           i_dir;
  logic                           i_en;
  logic                           i_rst;
  logic [1:0]                     i_ms;

  logic                           o_drive;
  logic                           o_dir;
  logic                           o_ms0;
  logic                           o_ms1;
  logic                           o_xen;
  logic                           o_xrst;
  logic                           o_busy;
  logic                           o_interrupt;
  logic                           o_aborted;
  logic [C_STEP_NUMBER_WIDTH-1:0] o_remain;
  logic [C_POS_WIDTH-1:0]         o_position;

  modport master (
    output i_clk_en, i_period_min, i_period_start, i_accel, i_ramp_en, i_step_nbr,
           i_start, i_stop, i_dir, i_en, i_rst, i_ms,
    input  o_drive, o_dir, o_ms0, o_ms1, o_xen, o_xrst, o_busy, o_interrupt,
           o_aborted, o_remain, o_position
  );

  modport slave (
    input  i_clk_en, i_period_min, i_period_start, i_accel, i_ramp_en, i_step_nbr,
           i_start, i_stop, i_dir, i_en, i_rst, i_ms,
    output o_drive, o_dir, o_ms0, o_ms1, o_xen, o_xrst, o_busy, o_interrupt,
           o_aborted, o_remain, o_position
  );
endinterface

// File: rtl/step_motor_ramp.sv
// Step/direction pulse generator with trapezoidal period ramp, abort handling
// and a signed wrapping position counter. All outputs are registered.
module step_motor_ramp #(
  parameter int C_STEP_NUMBER_WIDTH = 16,
  parameter int C_SPEED_DATA_WIDTH  = 16,
  parameter int C_CLK_DIV_BITS      = 5,
  parameter int C_PULSE_TICKS       = 4,
  parameter int C_POS_WIDTH         = 32
) (
  input  logic              clk,
  input  logic              resetn,
  step_motor_ramp_if.slave  bus
);
  localparam int SNW = C_STEP_NUMBER_WIDTH;
  localparam int SDW = C_SPEED_DATA_WIDTH;
  localparam logic [SDW-1:0] PULSE   = SDW'(C_PULSE_TICKS);
  localparam logic [SDW-1:0] MIN_EFF = SDW'(2 * C_PULSE_TICKS);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STOPPING} state_t;

  state_t                  state_q;
  logic [C_CLK_DIV_BITS-1:0] div_q;
  logic                    tick_q;
  logic [SDW-1:0]          cnt_q, low_ticks_q, cur_q, cur_d;
  logic [SDW-1:0]          start_per_q, min_per_q, accel_q;
  logic [SNW-1:0]          remain_q, ramp_cnt_q, ramp_cnt_d, remain_dec;
  logic [C_POS_WIDTH-1:0]  pos_q;
  logic                    ramp_en_q, dir_q;
  logic [1:0]              ms_q;
  logic                    drive_q, busy_q, irq_q, aborted_q, xen_q, xrst_q;
  logic [SDW:0]            sum_ext, diff_ext;
  logic [SDW-1:0]          eff_period;
  logic                    abort, phase_done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= bus.i_clk_en && (&div_q);
      if (bus.i_clk_en) div_q <= div_q + 1'b1;
    end
  end

  // Ramp next-period; the extra MSB catches overflow/underflow before clamping.
  always_comb begin
    remain_dec = remain_q - 1'b1;
    eff_period = (cur_q < MIN_EFF) ? MIN_EFF : cur_q;
    sum_ext    = {1'b0, cur_q} + {1'b0, accel_q};
    diff_ext   = {1'b0, cur_q} - {1'b0, accel_q};
    cur_d      = cur_q;
    ramp_cnt_d = ramp_cnt_q;
    if (ramp_en_q) begin
      if (remain_dec <= ramp_cnt_q) begin
        cur_d = (sum_ext > {1'b0, start_per_q}) ? start_per_q : sum_ext[SDW-1:0];
        if (ramp_cnt_q != '0) ramp_cnt_d = ramp_cnt_q - 1'b1;
      end else if (cur_q > min_per_q) begin
        cur_d = (diff_ext[SDW] || (diff_ext[SDW-1:0] < min_per_q)) ? min_per_q
                                                                   : diff_ext[SDW-1:0];
        ramp_cnt_d = ramp_cnt_q + 1'b1;
      end
    end
    abort      = busy_q && (bus.i_stop || !bus.i_en);
    phase_done = tick_q && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      low_ticks_q <= '0;
      cur_q       <= '0;
      start_per_q <= '0;
      min_per_q   <= '0;
      accel_q     <= '0;
      remain_q    <= '0;
      ramp_cnt_q  <= '0;
      pos_q       <= '0;
      ramp_en_q   <= 1'b0;
      dir_q       <= 1'b0;
      ms_q        <= 2'b00;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
      aborted_q   <= 1'b0;
      xen_q       <= 1'b0;
      xrst_q      <= 1'b0;
    end else begin
      xen_q  <= bus.i_en;
      xrst_q <= bus.i_rst;
      irq_q  <= 1'b0;
      if (tick_q && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.i_start && !bus.i_stop && bus.i_en) begin
            aborted_q <= 1'b0;
            if (bus.i_step_nbr == '0) begin
              irq_q    <= 1'b1;
              remain_q <= '0;
            end else begin
              state_q     <= LOW;
              busy_q      <= 1'b1;
              cnt_q       <= '0;
              remain_q    <= bus.i_step_nbr;
              dir_q       <= bus.i_dir;
              ms_q        <= bus.i_ms;
              ramp_en_q   <= bus.i_ramp_en;
              start_per_q <= bus.i_period_start;
              min_per_q   <= bus.i_period_min;
              accel_q     <= bus.i_accel;
              cur_q       <= bus.i_ramp_en ? bus.i_period_start : bus.i_period_min;
              ramp_cnt_q  <= '0;
            end
          end
        end
        LOW: begin
          if (abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            irq_q     <= 1'b1;
            aborted_q <= 1'b1;
          end else if (phase_done) begin
            if (remain_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              irq_q   <= 1'b1;
            end else begin
              state_q     <= HIGH;
              drive_q     <= 1'b1;
              cnt_q       <= PULSE - 1'b1;
              low_ticks_q <= eff_period - PULSE;
              remain_q    <= remain_dec;
              pos_q       <= dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
              cur_q       <= cur_d;
              ramp_cnt_q  <= ramp_cnt_d;
            end
          end
        end
        default: begin  // HIGH or STOPPING: the high time always runs to completion
          if (phase_done) begin
            drive_q <= 1'b0;
            if (abort || (state_q == STOPPING)) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              irq_q     <= 1'b1;
              aborted_q <= 1'b1;
            end else begin
              state_q <= LOW;
              cnt_q   <= low_ticks_q - 1'b1;
            end
          end else if (abort) begin
            state_q <= STOPPING;
          end
        end
      endcase
    end
  end

  assign bus.o_drive     = drive_q;
  assign bus.o_dir       = dir_q;
  assign bus.o_ms0       = ms_q[0];
  assign bus.o_ms1       = ms_q[1];
  assign bus.o_xen       = xen_q;
  assign bus.o_xrst      = xrst_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_interrupt = irq_q;
  assign bus.o_aborted   = aborted_q;
  assign bus.o_remain    = remain_q;
  assign bus.o_position  = pos_q;
endmodule

// File: tb/tb_step_motor_ramp.sv
// Bench for step_motor_ramp: tick = 4 clk, 2-tick pulses, 8-bit position.
module tb_step_motor_ramp;
  localparam int SNW = 16, SDW = 16, DIVB = 2, PT = 2, PW = 8, TICK = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0, failures = 0;
  int cyc = 0;
  int rise_q[$], fall_q[$], irq_q[$];
  int exp_per[$];
  int model_pos = 0;
  logic drive_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_motor_ramp_if #(.C_STEP_NUMBER_WIDTH(SNW), .C_SPEED_DATA_WIDTH(SDW),
                       .C_POS_WIDTH(PW)) bus ();

  step_motor_ramp #(.C_STEP_NUMBER_WIDTH(SNW), .C_SPEED_DATA_WIDTH(SDW),
                    .C_CLK_DIV_BITS(DIVB), .C_PULSE_TICKS(PT), .C_POS_WIDTH(PW))
    dut (.clk(clk), .resetn(resetn), .bus(bus));

  // Edge recorder: cycle numbers of drive rises/falls and interrupt cycles.
  always @(negedge clk) begin
    if (bus.o_drive && !drive_prev) rise_q.push_back(cyc);
    if (!bus.o_drive && drive_prev) fall_q.push_back(cyc);
    if (bus.o_interrupt) irq_q.push_back(cyc);
    drive_prev = bus.o_drive;
  end

  task automatic nclk(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_mon();
    rise_q.delete(); fall_q.delete(); irq_q.delete();
  endtask

  // Expected tick period of every step, straight from the ramp rules.
  task automatic build_model(input int n, input int ps, input int pm, input int acc,
                             input bit ramp);
    int cur, rc, r;
    exp_per.delete();
    cur = ramp ? ps : pm;
    rc = 0;
    for (int i = 0; i < n; i++) begin
      exp_per.push_back((cur < 2 * PT) ? 2 * PT : cur);
      r = n - 1 - i;
      if (ramp) begin
        if (r <= rc) begin
          cur = (cur + acc > ps) ? ps : cur + acc;
          if (rc > 0) rc--;
        end else if (cur > pm) begin
          cur = (cur - acc < pm) ? pm : cur - acc;
          rc++;
        end
      end
    end
  endtask

  task automatic issue_start(input int n, input int ps, input int pm, input int acc,
                             input bit ramp, input bit dir);
    bus.i_step_nbr = SNW'(n);
    bus.i_period_start = SDW'(ps);
    bus.i_period_min = SDW'(pm);
    bus.i_accel = SDW'(acc);
    bus.i_ramp_en = ramp;
    bus.i_dir = dir;
    bus.i_start = 1'b1;
    nclk(1);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (bus.o_busy && k < budget) begin nclk(1); k++; end
    if (k >= budget) begin
      checks++; failures++;
      $display("FAIL %s_timeout: busy still %0d after %0d cycles, required 0", name, bus.o_busy, budget);
    end
  endtask

  task automatic wait_rises(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (rise_q.size() < n && k < budget) begin nclk(1); k++; end
    if (k >= budget) begin
      checks++; failures++;
      $display("FAIL %s_rise_timeout: rises %0d, required %0d", name, rise_q.size(), n);
    end
  endtask

  // Runs one complete move against exp_per (filled by the caller).
  task automatic run_move(input string name, input int n, input int ps, input int pm,
                          input int acc, input bit ramp, input bit dir);
    int t1;
    clear_mon();
    issue_start(n, ps, pm, acc, ramp, dir);
    t1 = cyc;
    checks++;
    if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL %s_busy_rise: got %0d required 1", name, bus.o_busy); end
    wait_idle(name, 5000);
    nclk(2);
    model_pos = dir ? model_pos + n : model_pos - n;
    checks++;
    if (rise_q.size() !== n || fall_q.size() !== n) begin
      failures++;
      $display("FAIL %s_pulse_count: rises %0d falls %0d required %0d", name, rise_q.size(), fall_q.size(), n);
    end else begin
      checks++;
      if (rise_q[0] - t1 < 1 || rise_q[0] - t1 > TICK) begin
        failures++; $display("FAIL %s_first_latency: got %0d required 1..%0d", name, rise_q[0] - t1, TICK);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (fall_q[i] - rise_q[i] !== PT * TICK) begin
          failures++; $display("FAIL %s_high_width[%0d]: got %0d required %0d", name, i, fall_q[i] - rise_q[i], PT * TICK);
        end
        if (i < n - 1) begin
          checks++;
          if (rise_q[i + 1] - rise_q[i] !== TICK * exp_per[i]) begin
            failures++; $display("FAIL %s_period[%0d]: got %0d clk required %0d", name, i, rise_q[i + 1] - rise_q[i], TICK * exp_per[i]);
          end
        end
      end
      checks++;
      if (irq_q.size() !== 1) begin
        failures++; $display("FAIL %s_irq_count: got %0d required 1", name, irq_q.size());
      end else if (irq_q[0] - rise_q[n - 1] !== TICK * exp_per[n - 1]) begin
        failures++; $display("FAIL %s_irq_time: got %0d clk required %0d", name, irq_q[0] - rise_q[n - 1], TICK * exp_per[n - 1]);
      end
    end
    checks++;
    if (bus.o_position !== PW'(model_pos) || bus.o_remain !== '0 || bus.o_aborted !== 1'b0 || bus.o_dir !== dir) begin
      failures++;
      $display("FAIL %s_status: pos %0d remain %0d aborted %0d dir %0d required pos %0d remain 0 aborted 0 dir %0d",
               name, bus.o_position, bus.o_remain, bus.o_aborted, bus.o_dir, PW'(model_pos), dir);
    end
    $display("move %s: steps=%0d rises=%0d pos=%0d", name, n, rise_q.size(), bus.o_position);
  endtask

  task automatic test_reset();
    nclk(3);
    checks++;
    if ({bus.o_drive, bus.o_dir, bus.o_ms0, bus.o_ms1, bus.o_xen, bus.o_xrst, bus.o_busy,
         bus.o_interrupt, bus.o_aborted} !== 9'b0 || bus.o_remain !== '0 || bus.o_position !== '0) begin
      failures++; $display("FAIL reset_outputs: drive %0d xen %0d busy %0d remain %0d pos %0d required all 0",
                           bus.o_drive, bus.o_xen, bus.o_busy, bus.o_remain, bus.o_position);
    end
    resetn = 1'b1;
    bus.i_rst = 1'b1;
    nclk(1);
    checks++;
    if (bus.o_xrst !== 1'b1 || bus.o_xen !== 1'b1) begin
      failures++; $display("FAIL xen_xrst_follow: xrst %0d xen %0d required 1 1", bus.o_xrst, bus.o_xen);
    end
    bus.i_rst = 1'b0;
    nclk(1);
    checks++;
    if (bus.o_xrst !== 1'b0) begin failures++; $display("FAIL xrst_release: got %0d required 0", bus.o_xrst); end
    $display("reset: done");
  endtask

  task automatic test_constant();
    bus.i_ms = 2'b10;
    exp_per = '{10, 10, 10};
    run_move("constant", 3, 30, 10, 7, 1'b0, 1'b1);
    checks++;
    if (bus.o_ms0 !== 1'b0 || bus.o_ms1 !== 1'b1) begin
      failures++; $display("FAIL ms_latch: ms1 %0d ms0 %0d required 1 0", bus.o_ms1, bus.o_ms0);
    end
    bus.i_ms = 2'b00;
  endtask

  task automatic test_ramp();
    exp_per = '{20, 15, 10, 10, 15, 20};
    run_move("ramp6", 6, 20, 10, 5, 1'b1, 1'b1);
    exp_per = '{20, 15, 20};
    run_move("ramp3", 3, 20, 10, 5, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int n, ps, pm, acc;
    bit ramp, dir;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 8);
      pm = $urandom_range(1, 12);
      ps = pm + $urandom_range(0, 20);
      acc = $urandom_range(1, 8);
      ramp = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      build_model(n, ps, pm, acc, ramp);
      run_move("random", n, ps, pm, acc, ramp, dir);
    end
  endtask

  task automatic test_abort_high();
    clear_mon();
    issue_start(5, 10, 10, 0, 1'b0, 1'b1);
    wait_rises("abort_high", 2, 500);
    bus.i_stop = 1'b1;
    nclk(1);
    bus.i_stop = 1'b0;
    wait_idle("abort_high", 200);
    nclk(2);
    model_pos += 2;
    checks++;
    if (rise_q.size() !== 2 || fall_q.size() !== 2) begin
      failures++; $display("FAIL abort_high_pulses: rises %0d falls %0d required 2 2", rise_q.size(), fall_q.size());
    end else begin
      checks++;
      if (fall_q[1] - rise_q[1] !== PT * TICK) begin
        failures++; $display("FAIL abort_high_width: got %0d required %0d", fall_q[1] - rise_q[1], PT * TICK);
      end
      checks++;
      if (irq_q.size() !== 1 || irq_q[0] !== fall_q[1]) begin
        failures++; $display("FAIL abort_high_irq: count %0d required 1 at cycle %0d", irq_q.size(), fall_q[1]);
      end
    end
    checks++;
    if (bus.o_aborted !== 1'b1 || bus.o_remain !== 16'd3 || bus.o_position !== PW'(model_pos)) begin
      failures++; $display("FAIL abort_high_status: aborted %0d remain %0d pos %0d required 1 3 %0d",
                           bus.o_aborted, bus.o_remain, bus.o_position, PW'(model_pos));
    end
    $display("abort_high: remain=%0d aborted=%0d", bus.o_remain, bus.o_aborted);
  endtask

  task automatic test_abort_low();
    int k;
    clear_mon();
    issue_start(5, 10, 10, 0, 1'b0, 1'b0);
    k = 0;
    while (fall_q.size() < 1 && k < 500) begin nclk(1); k++; end
    bus.i_en = 1'b0;
    nclk(1);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_interrupt !== 1'b1 || bus.o_drive !== 1'b0) begin
      failures++; $display("FAIL abort_low_next: busy %0d irq %0d drive %0d required 0 1 0", bus.o_busy, bus.o_interrupt, bus.o_drive);
    end
    bus.i_en = 1'b1;
    nclk(2);
    model_pos -= 1;
    checks++;
    if (bus.o_aborted !== 1'b1 || bus.o_remain !== 16'd4 || irq_q.size() !== 1 || rise_q.size() !== 1) begin
      failures++; $display("FAIL abort_low_status: aborted %0d remain %0d irqs %0d rises %0d required 1 4 1 1",
                           bus.o_aborted, bus.o_remain, irq_q.size(), rise_q.size());
    end
    $display("abort_low: remain=%0d pos=%0d", bus.o_remain, bus.o_position);
  endtask

  task automatic test_ignored_and_zero();
    clear_mon();
    bus.i_step_nbr = 16'd4;
    bus.i_start = 1'b1; bus.i_stop = 1'b1;
    nclk(1);
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    bus.i_en = 1'b0; bus.i_start = 1'b1;
    nclk(1);
    bus.i_start = 1'b0; bus.i_en = 1'b1;
    nclk(3);
    checks++;
    if (bus.o_busy !== 1'b0 || irq_q.size() !== 0) begin
      failures++; $display("FAIL start_ignored: busy %0d irqs %0d required 0 0", bus.o_busy, irq_q.size());
    end
    bus.i_step_nbr = 16'd0;
    bus.i_start = 1'b1;
    nclk(1);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_interrupt !== 1'b1 || bus.o_busy !== 1'b0) begin
      failures++; $display("FAIL zero_step_irq: irq %0d busy %0d required 1 0", bus.o_interrupt, bus.o_busy);
    end
    nclk(1);
    checks++;
    if (bus.o_interrupt !== 1'b0) begin failures++; $display("FAIL zero_step_irq_width: got %0d required 0", bus.o_interrupt); end
    nclk(12);
    checks++;
    if (rise_q.size() !== 0 || bus.o_aborted !== 1'b0) begin
      failures++; $display("FAIL zero_step_motion: rises %0d aborted %0d required 0 0", rise_q.size(), bus.o_aborted);
    end
    $display("zero_step: irqs=%0d", irq_q.size());
  endtask

  task automatic test_start_while_busy();
    exp_per = '{10, 10, 10};
    clear_mon();
    issue_start(3, 10, 10, 0, 1'b0, 1'b1);
    wait_rises("busy_start", 1, 200);
    bus.i_step_nbr = 16'd7; bus.i_dir = 1'b0; bus.i_period_min = 16'd30;
    bus.i_start = 1'b1;
    nclk(1);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_remain !== 16'd2) begin failures++; $display("FAIL busy_start_remain: got %0d required 2", bus.o_remain); end
    wait_idle("busy_start", 2000);
    nclk(2);
    model_pos += 3;
    checks++;
    if (rise_q.size() !== 3 || bus.o_position !== PW'(model_pos) || bus.o_dir !== 1'b1) begin
      failures++; $display("FAIL busy_start_result: rises %0d pos %0d dir %0d required 3 %0d 1",
                           rise_q.size(), bus.o_position, bus.o_dir, PW'(model_pos));
    end
    checks++;
    if (rise_q.size() >= 2 && rise_q[1] - rise_q[0] !== TICK * exp_per[0]) begin
      failures++; $display("FAIL busy_start_period: got %0d required %0d", rise_q[1] - rise_q[0], TICK * exp_per[0]);
    end
    $display("start_while_busy: rises=%0d", rise_q.size());
  endtask

  task automatic test_reset_mid_move();
    clear_mon();
    issue_start(4, 1, 1, 0, 1'b0, 1'b1);
    wait_rises("reset_mid", 1, 200);
    resetn = 1'b0;
    nclk(1);
    checks++;
    if (bus.o_drive !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_position !== '0 || bus.o_interrupt !== 1'b0) begin
      failures++; $display("FAIL reset_mid_move: drive %0d busy %0d pos %0d irq %0d required 0 0 0 0",
                           bus.o_drive, bus.o_busy, bus.o_position, bus.o_interrupt);
    end
    nclk(2);
    resetn = 1'b1;
    model_pos = 0;
    nclk(2);
    checks++;
    if (irq_q.size() !== 0) begin failures++; $display("FAIL reset_mid_irq: got %0d required 0", irq_q.size()); end
    $display("reset_mid_move: pos=%0d", bus.o_position);
  endtask

  task automatic test_dir_neg();
    exp_per = '{10, 10};
    run_move("dir_neg", 2, 10, 10, 0, 1'b0, 1'b0);
    checks++;
    if (bus.o_position !== 8'hFE) begin failures++; $display("FAIL dir_neg_pos: got %0h required fe", bus.o_position); end
  endtask

  initial begin
    bus.i_clk_en = 1'b1; bus.i_en = 1'b1; bus.i_rst = 1'b0; bus.i_ms = 2'b00;
    bus.i_period_min = '0; bus.i_period_start = '0; bus.i_accel = '0; bus.i_ramp_en = 1'b0;
    bus.i_step_nbr = '0; bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_dir = 1'b0;
    test_reset();
    test_constant();
    test_ramp();
    test_random();
    test_abort_high();
    test_abort_low();
    test_ignored_and_zero();
    test_start_while_busy();
    exp_per = '{4, 4};
    run_move("min_period", 2, 1, 1, 0, 1'b0, 1'b1);
    test_reset_mid_move();
    test_dir_neg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
